// File: rtl/pkt_rr_arb_pkg.sv
// Switch-wide shared types and constants for the output-port arbiters.
package pkt_rr_arb_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } arb_state_e;

  localparam int DEFAULT_TIMEOUT = 255;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < value) r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/pkt_rr_arb_pick.sv
// Rotate-priority picker: first asserted req at or after base, wrapping upward.
module rr_pick #(
  parameter int NUM_PORT     = 4,
  parameter int LOG_NUM_PORT = 2
) (
  input  logic [NUM_PORT-1:0]     req,
  input  logic [LOG_NUM_PORT-1:0] base,
  output logic [NUM_PORT-1:0]     win,
  output logic [LOG_NUM_PORT-1:0] win_idx,
  output logic                    any
);

  // One extra bit so base+i can exceed NUM_PORT-1 before the wrap.
  localparam int IW = LOG_NUM_PORT + 1;
  localparam logic [IW-1:0] NP = IW'(NUM_PORT);

  logic [IW-1:0] idx;

  always_comb begin
    win     = '0;
    win_idx = '0;
    any     = 1'b0;
    idx     = '0;
    for (int i = 0; i < NUM_PORT; i++) begin
      idx = {1'b0, base} + IW'(i);
      if (idx >= NP) idx = idx - NP;
      if (!any && req[idx[LOG_NUM_PORT-1:0]]) begin
        any                          = 1'b1;
        win_idx                      = idx[LOG_NUM_PORT-1:0];
        win[idx[LOG_NUM_PORT-1:0]]   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pkt_rr_arb.sv
// Packet-granular round-robin arbiter for one output port, with stall watchdog.
// Handshake: a beat moves when out_valid & out_ready; in_ready mirrors out_ready on the granted input only.
module pkt_rr_arb
  import pkt_rr_arb_pkg::*;
#(
  parameter int NUM_PORT     = 4,
  parameter int LOG_NUM_PORT = 2,
  parameter int TIMEOUT      = DEFAULT_TIMEOUT,
  parameter int TO_W         = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic [NUM_PORT-1:0]     in_valid,
  input  logic [NUM_PORT-1:0]     in_eop,
  output logic [NUM_PORT-1:0]     in_ready,
  input  logic                    out_ready,
  output logic                    out_valid,
  output logic                    out_eop,
  output logic [LOG_NUM_PORT-1:0] out_sel,
  output logic [NUM_PORT-1:0]     grant,
  output logic                    busy,
  output logic                    timeout_err
);

  localparam logic [LOG_NUM_PORT-1:0] LAST_PORT = LOG_NUM_PORT'(NUM_PORT - 1);
  localparam logic [TO_W-1:0]         WD_LAST   = TO_W'(TIMEOUT - 1);

  arb_state_e              state_q, state_d;
  logic [NUM_PORT-1:0]     grant_q, grant_d;
  logic [LOG_NUM_PORT-1:0] sel_q, sel_d;
  logic [LOG_NUM_PORT-1:0] last_q, last_d;
  logic [TO_W-1:0]         wd_q, wd_d;
  logic                    to_q, to_d;

  logic [LOG_NUM_PORT-1:0] base;
  logic [NUM_PORT-1:0]     pick_win;
  logic [LOG_NUM_PORT-1:0] pick_idx;
  logic                    pick_any;

  assign base = (last_q == LAST_PORT) ? '0 : last_q + 1'b1;

  rr_pick #(
    .NUM_PORT     (NUM_PORT),
    .LOG_NUM_PORT (LOG_NUM_PORT)
  ) u_pick (
    .req     (in_valid),
    .base    (base),
    .win     (pick_win),
    .win_idx (pick_idx),
    .any     (pick_any)
  );

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    sel_d     = sel_q;
    last_d    = last_q;
    wd_d      = wd_q;
    to_d      = 1'b0;
    out_valid = 1'b0;
    out_eop   = 1'b0;
    in_ready  = '0;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          state_d = ST_LOCK;
          grant_d = pick_win;
          sel_d   = pick_idx;
          wd_d    = '0;
        end
      end
      ST_LOCK: begin
        // A clear cycle must not accept a beat it is about to discard.
        out_valid       = in_valid[sel_q] & ~clr;
        out_eop         = in_valid[sel_q] & in_eop[sel_q] & ~clr;
        in_ready[sel_q] = out_ready & ~clr;
        if (out_valid && out_ready) begin
          if (out_eop) begin
            last_d  = sel_q;
            grant_d = '0;
            state_d = ST_IDLE;
          end else begin
            wd_d = '0;
          end
        end else if (wd_q == WD_LAST) begin
          to_d    = 1'b1;
          last_d  = sel_q;
          grant_d = '0;
          state_d = ST_IDLE;
        end else if (wd_q != '1) begin
          wd_d = wd_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (clr) begin
      state_d = ST_IDLE;
      grant_d = '0;
      sel_d   = '0;
      last_d  = LAST_PORT;
      wd_d    = '0;
      to_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      sel_q   <= '0;
      last_q  <= LAST_PORT;
      wd_q    <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      wd_q    <= wd_d;
      to_q    <= to_d;
    end
  end

  assign grant       = grant_q;
  assign out_sel     = sel_q;
  assign busy        = (state_q == ST_LOCK);
  assign timeout_err = to_q;

endmodule

// File: tb/tb_pkt_rr_arb.sv
// Self-checking bench for pkt_rr_arb: vector table, directed corner sequences, random traffic vs reference model.
module tb_pkt_rr_arb;

  localparam int N  = 4;
  localparam int LN = 2;
  localparam int T  = 12;
  localparam int TW = 4;

  logic          clk       = 1'b0;
  logic          rst_n     = 1'b1;
  logic          clr       = 1'b0;
  logic [N-1:0]  in_valid  = '0;
  logic [N-1:0]  in_eop    = '0;
  logic [N-1:0]  in_ready;
  logic          out_ready = 1'b0;
  logic          out_valid;
  logic          out_eop;
  logic [LN-1:0] out_sel;
  logic [N-1:0]  grant;
  logic          busy;
  logic          timeout_err;

  always #5 clk = ~clk;

  pkt_rr_arb #(
    .NUM_PORT     (N),
    .LOG_NUM_PORT (LN),
    .TIMEOUT      (T),
    .TO_W         (TW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr         (clr),
    .in_valid    (in_valid),
    .in_eop      (in_eop),
    .in_ready    (in_ready),
    .out_ready   (out_ready),
    .out_valid   (out_valid),
    .out_eop     (out_eop),
    .out_sel     (out_sel),
    .grant       (grant),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: which port holds the packet, who was served last, how long it has stalled.
  bit m_lock;
  int m_g, m_sel, m_last, m_idle;
  bit m_to;

  task automatic model_reset();
    m_lock = 0; m_g = 0; m_sel = 0; m_last = N - 1; m_idle = 0; m_to = 0;
  endtask

  function automatic logic [13:0] model_out();
    logic [N-1:0] oh;
    logic [N-1:0] rdy;
    bit live, ev;
    oh = '0;
    rdy = '0;
    if (m_lock) oh[m_g] = 1'b1;
    live = m_lock && !clr;
    ev = live && in_valid[m_g];
    if (live && out_ready) rdy = oh;
    return {rdy, ev, ev && in_eop[m_g], LN'(m_sel), oh, m_lock, m_to};
  endfunction

  task automatic model_advance();
    bit beat, found;
    int p;
    if (clr) begin
      model_reset();
    end else if (!m_lock) begin
      m_to = 0;
      found = 0;
      for (int j = 0; j < N; j++) begin
        p = (m_last + 1 + j) % N;
        if (!found && in_valid[p]) begin
          found = 1; m_lock = 1; m_g = p; m_sel = p; m_idle = 0;
        end
      end
    end else begin
      m_to = 0;
      beat = in_valid[m_g] && out_ready;
      if (beat && in_eop[m_g]) begin
        m_last = m_g; m_lock = 0;
      end else if (beat) begin
        m_idle = 0;
      end else if (m_idle == T - 1) begin
        m_to = 1; m_last = m_g; m_lock = 0;
      end else begin
        m_idle++;
      end
    end
  endtask

  // Packet sources: per-port length and beat position drive in_eop.
  int           src_len[N];
  int           src_cnt[N];
  bit           src_on[N];
  logic [N-1:0] gate = '1;
  bit           use_src = 0;
  bit           rnd_len = 0;

  task automatic apply_src();
    for (int p = 0; p < N; p++) begin
      in_valid[p] = src_on[p] & gate[p];
      in_eop[p]   = (src_cnt[p] == src_len[p] - 1);
    end
  endtask

  task automatic tick();
    logic [N-1:0] acc;
    @(negedge clk);
    check("outputs", {in_ready, out_valid, out_eop, out_sel, grant, busy, timeout_err}, model_out());
    acc = in_valid & in_ready;
    model_advance();
    @(posedge clk);
    #1;
    if (use_src) begin
      for (int p = 0; p < N; p++) begin
        if (acc[p]) begin
          if (src_cnt[p] == src_len[p] - 1) begin
            src_cnt[p] = 0;
            if (rnd_len) src_len[p] = $urandom_range(1, 4);
          end else begin
            src_cnt[p]++;
          end
        end
      end
      apply_src();
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clr = 1'b0;
    use_src = 0;
    #1;
    check("reset_outputs", {in_ready, out_valid, out_eop, out_sel, grant, busy, timeout_err}, 32'h0);
    model_reset();
    for (int p = 0; p < N; p++) begin
      src_len[p] = 1; src_cnt[p] = 0; src_on[p] = 0;
    end
    gate = '1;
    in_valid = '0;
    in_eop = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [N-1:0]  v;
    logic [N-1:0]  e;
    logic [N-1:0]  eg;
    logic [N-1:0]  er;
    logic          ev;
    logic [LN-1:0] es;
  } vec_t;

  vec_t tv[12];
  logic [N-1:0] gseq[8];

  initial begin
    #400000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int locks, busy_cycles, found;
    bit prev_busy;

    // Single-beat packets from port 2, then 1011 traffic to exercise the wrap.
    tv[0]  = '{4'b0100, 4'b0100, 4'b0000, 4'b0000, 1'b0, 2'd0};
    tv[1]  = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 1'b1, 2'd2};
    tv[2]  = '{4'b0100, 4'b0100, 4'b0000, 4'b0000, 1'b0, 2'd2};
    tv[3]  = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 1'b1, 2'd2};
    tv[4]  = '{4'b0100, 4'b0100, 4'b0000, 4'b0000, 1'b0, 2'd2};
    tv[5]  = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 1'b1, 2'd2};
    tv[6]  = '{4'b1011, 4'b1011, 4'b0000, 4'b0000, 1'b0, 2'd2};
    tv[7]  = '{4'b1011, 4'b1011, 4'b1000, 4'b1000, 1'b1, 2'd3};
    tv[8]  = '{4'b1011, 4'b1011, 4'b0000, 4'b0000, 1'b0, 2'd3};
    tv[9]  = '{4'b1011, 4'b1011, 4'b0001, 4'b0001, 1'b1, 2'd0};
    tv[10] = '{4'b1011, 4'b1011, 4'b0000, 4'b0000, 1'b0, 2'd0};
    tv[11] = '{4'b1011, 4'b1011, 4'b0010, 4'b0010, 1'b1, 2'd1};

    // Fairness: all ports valid, 3-beat packets.
    do_reset();
    for (int p = 0; p < N; p++) begin
      src_len[p] = 3; src_on[p] = 1;
    end
    use_src = 1; rnd_len = 0; out_ready = 1'b1;
    apply_src();
    locks = 0; busy_cycles = 0; prev_busy = 0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (busy && !prev_busy && locks < 8) begin
        gseq[locks] = grant;
        locks++;
      end
      if (busy) busy_cycles++;
      prev_busy = busy;
      tick();
    end
    check("t1_lock_count", locks, 5);
    check("t1_busy_cycles", busy_cycles, 15);
    check("t1_grant0", gseq[0], 4'b0001);
    check("t1_grant1", gseq[1], 4'b0010);
    check("t1_grant2", gseq[2], 4'b0100);
    check("t1_grant3", gseq[3], 4'b1000);
    check("t1_grant4", gseq[4], 4'b0001);

    // Vector table.
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      in_valid = tv[i].v;
      in_eop = tv[i].e;
      #1;
      check("t2_vec", {grant, out_valid, out_sel, in_ready, timeout_err},
            {tv[i].eg, tv[i].ev, tv[i].es, tv[i].er, 1'b0});
      tick();
    end

    // Backpressure mid-packet on port 1 while port 3 waits.
    do_reset();
    src_on[1] = 1; src_len[1] = 4;
    src_on[3] = 1; src_len[3] = 2;
    use_src = 1; rnd_len = 0; out_ready = 1'b1;
    apply_src();
    tick();
    tick();
    tick();
    out_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      #1;
      check("t3_rdy3_low", in_ready[3], 1'b0);
      check("t3_port1_lock", grant, 4'b0010);
      tick();
    end
    out_ready = 1'b1;
    tick();
    tick();
    tick();
    check("t3_next_port3", grant, 4'b1000);

    // Watchdog expiry after port 0 stalls.
    do_reset();
    in_valid = 4'b0011; in_eop = 4'b0000; out_ready = 1'b1;
    tick();
    tick();
    in_valid = 4'b0010;
    found = -1;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (timeout_err) begin
        found = k + 1;
        break;
      end
    end
    check("t4_timeout_delay", found, T);
    check("t4_released", {busy, grant}, 5'b0);
    tick();
    check("t4_pulse_width", timeout_err, 1'b0);
    check("t4_next_port1", grant, 4'b0010);

    // EOP beat in the watchdog's final cycle wins.
    do_reset();
    in_valid = 4'b0001; in_eop = 4'b0000; out_ready = 1'b1;
    tick();
    tick();
    in_valid = 4'b0000;
    repeat (T - 1) tick();
    check("t5_still_locked", {busy, timeout_err}, 2'b10);
    in_valid = 4'b0001; in_eop = 4'b0001;
    tick();
    check("t5_no_timeout", timeout_err, 1'b0);
    check("t5_release", {busy, grant}, 5'b0);
    in_valid = 4'b0000;
    tick();
    check("t5_no_late_timeout", timeout_err, 1'b0);

    // Clear mid-packet on port 2.
    do_reset();
    in_valid = 4'b0100; in_eop = 4'b0000; out_ready = 1'b1;
    tick();
    tick();
    check("t6_locked2", grant, 4'b0100);
    clr = 1'b1; in_valid = 4'b0101;
    tick();
    clr = 1'b0;
    check("t6_cleared", {busy, grant, out_sel}, 7'b0);
    tick();
    check("t6_port0_first", grant, 4'b0001);

    // Random traffic, with do_reset also landing mid-packet.
    do_reset();
    for (int p = 0; p < N; p++) begin
      src_len[p] = $urandom_range(1, 4); src_on[p] = 1;
    end
    use_src = 1; rnd_len = 1;
    for (int c = 0; c < 800; c++) begin
      for (int p = 0; p < N; p++) begin
        if ($urandom_range(0, 29) == 0) src_on[p] = ~src_on[p];
        gate[p] = ($urandom_range(0, 9) != 0);
      end
      out_ready = ($urandom_range(0, 6) != 0);
      clr = ($urandom_range(0, 149) == 0);
      apply_src();
      tick();
    end
    clr = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
